cpu_out_display: RTL and testbench

Board-side consumer of the CPU's 8-bit cpuOut bus. The switches feed the CPU's input side; this block drives the other end, a 4-digit multiplexed seven-segment display. It latches each new cpuOut value and converts it to 3-digit BCD with a sequential double-dabble (shift-and-add-3) engine. It then scans the digits continuously, with optional two's-complement display.

---
 rtl/cpu_out_display.sv | 142 ++++++++++++++
 tb/tb_cpu_out_display.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/cpu_out_display.sv
// Latches the CPU output byte, converts it to 3-digit BCD with a sequential
// double-dabble engine and scans it onto a 4-digit active-low 7-segment display.
module cpu_out_display #(
  parameter int REFRESH_DIV = 50000
) (
  input  logic        boardCLK,
  input  logic        reset,
  input  logic [7:0]  cpuOut,
  input  logic        signedMode,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an,
  output logic [11:0] bcdOut,
  output logic        negOut,
  output logic        busy
);

  localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;

  typedef enum logic [1:0] {IDLE, CONVERT, COMMIT} state_t;

  state_t      state, state_nxt;
  logic [7:0]  cap_val;
  logic        cap_signed;
  logic        neg;
  logic [19:0] shift;
  logic [2:0]  iter;
  logic        changed, in_neg;
  logic [7:0]  mag;
  logic [19:0] adj;

  logic [CW-1:0] cnt;
  logic [1:0]    idx, idx_nxt;
  logic          wrap;
  logic [6:0]    seg_nxt;

  function automatic logic [6:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0:    seg_code = 7'b1000000;
      4'd1:    seg_code = 7'b1111001;
      4'd2:    seg_code = 7'b0100100;
      4'd3:    seg_code = 7'b0110000;
      4'd4:    seg_code = 7'b0011001;
      4'd5:    seg_code = 7'b0010010;
      4'd6:    seg_code = 7'b0000010;
      4'd7:    seg_code = 7'b1111000;
      4'd8:    seg_code = 7'b0000000;
      4'd9:    seg_code = 7'b0010000;
      default: seg_code = SEG_BLANK;
    endcase
  endfunction

  always_comb begin
    changed = ({cpuOut, signedMode} != {cap_val, cap_signed});
    in_neg  = signedMode & cpuOut[7];
    mag     = in_neg ? (~cpuOut + 8'd1) : cpuOut;
    // add-3 correction on the three BCD nibbles before each shift
    adj = shift;
    for (int k = 2; k < 5; k++)
      if (shift[4*k +: 4] >= 4'd5) adj[4*k +: 4] = shift[4*k +: 4] + 4'd3;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (changed) state_nxt = CONVERT;
      CONVERT: if (iter == 3'd7) state_nxt = COMMIT;
      COMMIT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge boardCLK or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge boardCLK or negedge reset) begin
    if (!reset) begin
      cap_val    <= '0;
      cap_signed <= 1'b0;
      neg        <= 1'b0;
      shift      <= '0;
      iter       <= '0;
      bcdOut     <= '0;
      negOut     <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: if (changed) begin
          cap_val    <= cpuOut;
          cap_signed <= signedMode;
          neg        <= in_neg;
          shift      <= {12'b0, mag};
          iter       <= '0;
          busy       <= 1'b1;
        end
        CONVERT: begin
          shift <= {adj[18:0], 1'b0};
          iter  <= iter + 3'd1;
        end
        COMMIT: begin
          bcdOut <= shift[19:8];
          negOut <= neg;
          busy   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Digit scan: segments follow the committed value only
  always_comb begin
    wrap    = (cnt == CW'(REFRESH_DIV - 1));
    idx_nxt = wrap ? idx + 2'd1 : idx;
    case (idx_nxt)
      2'd0:    seg_nxt = seg_code(bcdOut[3:0]);
      2'd1:    seg_nxt = (bcdOut[11:4] == 8'd0) ? SEG_BLANK : seg_code(bcdOut[7:4]);
      2'd2:    seg_nxt = (bcdOut[11:8] == 4'd0) ? SEG_BLANK : seg_code(bcdOut[11:8]);
      default: seg_nxt = negOut ? SEG_MINUS : SEG_BLANK;
    endcase
  end

  always_ff @(posedge boardCLK or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
      idx <= '0;
      an  <= 4'b1110;
      seg <= 7'b1000000;
    end else begin
      cnt <= wrap ? '0 : cnt + CW'(1);
      idx <= idx_nxt;
      an  <= ~(4'b0001 << idx_nxt);
      seg <= seg_nxt;
    end
  end

  assign dp = 1'b1;

endmodule

// File: tb/tb_cpu_out_display.sv
// Directed bench for cpu_out_display: conversion latency, signed corners,
// mid-conversion input changes, mid-conversion reset and the digit scan.
module tb_cpu_out_display;

  logic        boardCLK = 1'b0;
  logic        reset;
  logic [7:0]  cpuOut;
  logic        signedMode;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic [11:0] bcdOut;
  logic        negOut;
  logic        busy;

  int checks = 0;
  int errors = 0;

  cpu_out_display #(.REFRESH_DIV(4)) dut (
    .boardCLK(boardCLK), .reset(reset), .cpuOut(cpuOut), .signedMode(signedMode),
    .seg(seg), .dp(dp), .an(an), .bcdOut(bcdOut), .negOut(negOut), .busy(busy)
  );

  always #5 boardCLK = ~boardCLK;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge boardCLK);
      #1;
    end
  endtask

  task automatic test_reset;
    reset = 1'b0; cpuOut = 8'h00; signedMode = 1'b0;
    tick(2);
    checks++; if (an !== 4'b1110) begin errors++; $display("FAIL reset_an got %b exp 1110", an); end
    checks++; if (seg !== 7'b1000000) begin errors++; $display("FAIL reset_seg got %b exp 1000000", seg); end
    checks++; if (dp !== 1'b1) begin errors++; $display("FAIL reset_dp got %b exp 1", dp); end
    checks++; if (bcdOut !== 12'h000) begin errors++; $display("FAIL reset_bcd got %h exp 000", bcdOut); end
    checks++; if (busy !== 1'b0 || negOut !== 1'b0) begin errors++; $display("FAIL reset_busy_neg got %b%b exp 00", busy, negOut); end
    reset = 1'b1;
    tick(5);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_no_conv busy got %b exp 0", busy); end
  endtask

  task automatic test_convert;
    logic [3:0] exp_an [4];
    logic [6:0] exp_seg [4];
    bit found;
    int busy_cnt;
    exp_an  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    exp_seg = '{7'b0011001, 7'b1000000, 7'b1111001, 7'b1111111};
    cpuOut = 8'b0110_1000; signedMode = 1'b0;
    busy_cnt = 0;
    for (int i = 0; i < 9; i++) begin
      tick(1);
      if (busy === 1'b1) busy_cnt++;
    end
    checks++; if (busy_cnt != 9) begin errors++; $display("FAIL conv_busy_cycles got %0d exp 9", busy_cnt); end
    checks++; if (bcdOut !== 12'h000) begin errors++; $display("FAIL conv_bcd_early got %h exp 000", bcdOut); end
    tick(1);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL conv_busy_end got %b exp 0", busy); end
    checks++; if (bcdOut !== 12'h104 || negOut !== 1'b0) begin errors++; $display("FAIL conv_104 got %h/%b exp 104/0", bcdOut, negOut); end
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick(1);
      if (an === 4'b1110) found = 1;
    end
    checks++; if (!found) begin errors++; $display("FAIL scan_sync an got %b exp 1110", an); end
    for (int k = 0; k < 4; k++) begin
      checks++; if (an !== exp_an[k]) begin errors++; $display("FAIL scan104_an%0d got %b exp %b", k, an, exp_an[k]); end
      checks++; if (seg !== exp_seg[k]) begin errors++; $display("FAIL scan104_seg%0d got %b exp %b", k, seg, exp_seg[k]); end
      tick(4);
    end
  endtask

  task automatic test_signed;
    logic [6:0] exp_seg [4];
    bit found;
    exp_seg = '{7'b1111001, 7'b1111111, 7'b1111111, 7'b0111111};
    cpuOut = 8'hFF; signedMode = 1'b1;
    tick(10);
    checks++; if (bcdOut !== 12'h001 || negOut !== 1'b1) begin errors++; $display("FAIL signed_ff got %h/%b exp 001/1", bcdOut, negOut); end
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick(1);
      if (an === 4'b1110) found = 1;
    end
    checks++; if (!found) begin errors++; $display("FAIL scan_sync_neg an got %b exp 1110", an); end
    for (int k = 0; k < 4; k++) begin
      checks++; if (seg !== exp_seg[k]) begin errors++; $display("FAIL scanneg_seg%0d got %b exp %b", k, seg, exp_seg[k]); end
      tick(4);
    end
    cpuOut = 8'h80; signedMode = 1'b1;
    tick(10);
    checks++; if (bcdOut !== 12'h128 || negOut !== 1'b1) begin errors++; $display("FAIL signed_80 got %h/%b exp 128/1", bcdOut, negOut); end
    cpuOut = 8'hFF; signedMode = 1'b0;
    tick(10);
    checks++; if (bcdOut !== 12'h255 || negOut !== 1'b0) begin errors++; $display("FAIL unsigned_ff got %h/%b exp 255/0", bcdOut, negOut); end
  endtask

  task automatic test_back_to_back;
    cpuOut = 8'h68; signedMode = 1'b0;
    tick(3);
    cpuOut = 8'h05;
    tick(7);
    checks++; if (bcdOut !== 12'h104 || busy !== 1'b0) begin errors++; $display("FAIL b2b_first got %h/%b exp 104/0", bcdOut, busy); end
    tick(1);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_restart busy got %b exp 1", busy); end
    tick(8);
    checks++; if (bcdOut !== 12'h104) begin errors++; $display("FAIL b2b_hold got %h exp 104", bcdOut); end
    tick(1);
    checks++; if (bcdOut !== 12'h005 || busy !== 1'b0) begin errors++; $display("FAIL b2b_second got %h/%b exp 005/0", bcdOut, busy); end
  endtask

  task automatic test_signed_toggle;
    cpuOut = 8'hF6; signedMode = 1'b0;
    tick(10);
    checks++; if (bcdOut !== 12'h246 || negOut !== 1'b0) begin errors++; $display("FAIL toggle_unsigned got %h/%b exp 246/0", bcdOut, negOut); end
    signedMode = 1'b1;
    tick(9);
    checks++; if (bcdOut !== 12'h246) begin errors++; $display("FAIL toggle_hold got %h exp 246", bcdOut); end
    tick(1);
    checks++; if (bcdOut !== 12'h010 || negOut !== 1'b1) begin errors++; $display("FAIL toggle_signed got %h/%b exp 010/1", bcdOut, negOut); end
  endtask

  task automatic test_reset_mid;
    cpuOut = 8'hC8; signedMode = 1'b0;
    tick(5);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy got %b exp 1", busy); end
    reset = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || bcdOut !== 12'h000 || negOut !== 1'b0) begin errors++; $display("FAIL mid_reset_state got %b/%h/%b exp 0/000/0", busy, bcdOut, negOut); end
    checks++; if (an !== 4'b1110 || seg !== 7'b1000000) begin errors++; $display("FAIL mid_reset_disp got %b/%b exp 1110/1000000", an, seg); end
    tick(2);
    reset = 1'b1;
    tick(9);
    checks++; if (busy !== 1'b1 || bcdOut !== 12'h000) begin errors++; $display("FAIL reconv_busy got %b/%h exp 1/000", busy, bcdOut); end
    tick(1);
    checks++; if (bcdOut !== 12'h200 || busy !== 1'b0) begin errors++; $display("FAIL reconv_200 got %h/%b exp 200/0", bcdOut, busy); end
  endtask

  initial begin
    test_reset;
    test_convert;
    test_signed;
    test_back_to_back;
    test_signed_toggle;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
